// File: rtl/mac_pkg.sv
// Shared MAC types and the round/saturate helper used by result requantizers.
// Latency: n/a (package: types, constants, combinational function).
// Backpressure: n/a.
package mac_pkg;

    localparam int ACC_W  = 28;
    localparam int OPND_W = 14;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [OPND_W-1:0] opnd_t;

    // Round-half-up right shift by 'shift', then clamp to a signed 'out_w'-bit
    // range. The result is returned sign-extended in an acc_t. The sum is formed
    // one bit wider than the accumulator so adding the rounding constant to the
    // most positive accumulator value cannot wrap.
    function automatic acc_t sat_round(input acc_t x, input int unsigned shift,
                                       input int unsigned out_w);
        logic signed [ACC_W:0] v_ext;
        logic signed [ACC_W:0] v_half;
        logic signed [ACC_W:0] v_r;
        logic signed [ACC_W:0] v_max;
        logic signed [ACC_W:0] v_min;
        logic signed [ACC_W:0] v_sat;
        v_ext  = {x[ACC_W-1], x};
        v_half = '0;
        if (shift == 0) begin
            v_r = v_ext;
        end else begin
            v_half = (ACC_W+1)'(1) << (shift - 1);
            v_r    = (v_ext + v_half) >>> shift;
        end
        v_max = ((ACC_W+1)'(1) << (out_w - 1)) - (ACC_W+1)'(1);
        v_min = ~v_max;
        if (v_r > v_max) begin
            v_sat = v_max;
        end else if (v_r < v_min) begin
            v_sat = v_min;
        end else begin
            v_sat = v_r;
        end
        return v_sat[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Single-clock FIFO, DEPTH x W; head is visible combinationally (0 when empty).
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push ignored when full unless a pop happens on the same edge;
//   pop ignored when empty. Drop policy belongs to the caller.
// Ports: clk, reset (async active-low), push/push_dat, pop/pop_dat, level, full.
module mac_result_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_empty;

    assign w_empty   = (r_level == '0);
    assign full      = (r_level == FULL_LVL);
    assign w_do_pop  = pop && !w_empty;
    // A pop frees the slot on the same edge, so a full FIFO still takes the push.
    assign w_do_push = push && (!full || w_do_pop);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_dat;
    end

    assign pop_dat = w_empty ? '0 : r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule

// File: rtl/mac_result_quantizer.sv
// Quantizes MAC accumulator results (optional ReLU, round-half-up shift, saturate) into a FIFO.
// Latency: result presented before edge A is captured at A, written at A+1, at the head after A+1.
// Backpressure: output is valid/ready; the MAC cannot stall, so a full FIFO drops and sets sticky overflow.
// Ports: clk, reset (async active-low), in_valid/in_data from MAC, out_valid/out_data/out_ready stream,
//   level (occupancy), overflow (sticky drop flag), clr_ovf (synchronous clear).
// Build option: define RELU_QUANT_EN to clamp negative results to 0 before rounding.
module mac_result_quantizer #(
    parameter int ACC_W = 28,
    parameter int OUT_W = 14,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [ACC_W-1:0]         in_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    import mac_pkg::*;

    acc_t             w_x;
    acc_t             w_qin;
    acc_t             w_sat;
    logic [OUT_W-1:0] w_q;
    logic             w_sat_unused_hi;

    logic             r_s1_vld;
    logic [OUT_W-1:0] r_s1_q;
    logic             r_ovf;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_x = acc_t'(in_data);

`ifdef RELU_QUANT_EN
    assign w_qin = w_x[$bits(acc_t)-1] ? '0 : w_x;
`else
    assign w_qin = w_x;
`endif

    // Saturated value already fits OUT_W; upper bits are pure sign extension.
    assign w_sat           = sat_round(w_qin, SHIFT, OUT_W);
    assign w_q             = w_sat[OUT_W-1:0];
    assign w_sat_unused_hi = ^w_sat[$bits(acc_t)-1:OUT_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld <= 1'b0;
            r_s1_q   <= '0;
        end else begin
            r_s1_vld <= in_valid;
            if (in_valid) r_s1_q <= w_q;
        end
    end

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_s1_vld && (!w_full || w_pop);
    assign w_drop = r_s1_vld && w_full && !w_pop;

    // A drop on the same edge as clr_ovf wins, so no loss goes unreported.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    mac_result_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_dat (r_s1_q),
        .pop      (w_pop),
        .pop_dat  (out_data),
        .level    (level),
        .full     (w_full)
    );

    assign out_valid = (level != '0);
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_result_quantizer.sv
// Bench for mac_result_quantizer: SHIFT=4 main instance plus a SHIFT=0 instance.
// Latency: n/a. Backpressure: bench drives out_ready explicitly per test.
module tb_mac_result_quantizer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [27:0] in_data;
    logic        out_valid;
    logic [13:0] out_data;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;

    logic        o0_valid;
    logic [13:0] o0_data;
    logic [2:0]  o0_level;
    logic        o0_ovf;

    int n_total = 0;
    int n_bad   = 0;
    int sb[$];

    typedef struct {
        int din;
        int e4;
        int e0;
    } vec_t;

    vec_t tv[14];

    mac_result_quantizer #(.ACC_W(28), .OUT_W(14), .SHIFT(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .overflow(overflow), .clr_ovf(clr_ovf));

    mac_result_quantizer #(.ACC_W(28), .OUT_W(14), .SHIFT(0), .DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o0_valid), .out_data(o0_data), .out_ready(1'b1),
        .level(o0_level), .overflow(o0_ovf), .clr_ovf(1'b0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rexp(input int din, input int e);
`ifdef RELU_QUANT_EN
        return (din < 0) ? 0 : e;
`else
        return e;
`endif
    endfunction

    task automatic drive(input int din, input int e);
        in_valid = 1'b1;
        in_data  = 28'(din);
        sb.push_back(rexp(din, e));
    endtask

    // Scoreboard: a pop happens at the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_unexpected: got %0d want no output", $signed(out_data));
            end else begin
                chk("sb_order", $signed(out_data), sb.pop_front());
            end
        end
    end

    initial begin
        tv[0]  = '{160, 10, 160};
        tv[1]  = '{134217727, 8191, 8191};
        tv[2]  = '{-134217728, -8192, -8192};
        tv[3]  = '{24, 2, 24};
        tv[4]  = '{-24, -1, -24};
        tv[5]  = '{-100, -6, -100};
        tv[6]  = '{5, 0, 5};
        tv[7]  = '{9000, 563, 8191};
        tv[8]  = '{8, 1, 8};
        tv[9]  = '{-8, 0, -8};
        tv[10] = '{131064, 8191, 8191};
        tv[11] = '{131063, 8191, 8191};
        tv[12] = '{-131072, -8192, -8192};
        tv[13] = '{-131090, -8192, -8192};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b1;
        step();

        // Single results through the pipe, consumer always ready.
        out_ready = 1'b1;
        foreach (tv[i]) begin
            drive(tv[i].din, tv[i].e4);
            step();
            in_valid = 1'b0;
            chk("lat_early_valid", out_valid, 0);
            step();
            chk("lat_valid", out_valid, 1);
            chk("vec_data", $signed(out_data), rexp(tv[i].din, tv[i].e4));
            chk("sh0_valid", o0_valid, 1);
            chk("sh0_data", $signed(o0_data), rexp(tv[i].din, tv[i].e0));
            step();
            chk("vec_drained_valid", out_valid, 0);
            chk("vec_drained_level", level, 0);
        end

        // Overflow: five back-to-back results into a stalled 4-deep FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 28'(k * 16);
            if (k <= 4) sb.push_back(k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", $signed(out_data), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("ovf_drain_level", level, 0);
        chk("ovf_drain_sb", sb.size(), 0);

        // Full FIFO with a pop on the same edge as the incoming write.
        out_ready = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            drive(k * 16, k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("full_level", level, 4);
        drive(160, 10);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pushpop_level", level, 4);
        chk("pushpop_ovf", overflow, 0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("pushpop_drain_level", level, 0);
        chk("pushpop_drain_sb", sb.size(), 0);

        // Reset with two entries queued and one in stage 1.
        out_ready = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            drive(k * 16, k);
            step();
        end
        in_valid = 1'b0;
        chk("prerst_level", level, 2);
        reset = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_level", level, 0);
        sb.delete();
        reset = 1'b1;
        step();
        chk("postrst_valid", out_valid, 0);
        chk("postrst_level", level, 0);
        out_ready = 1'b1;
        drive(224, 14);
        step();
        in_valid = 1'b0;
        chk("postrst_early", out_valid, 0);
        step();
        chk("postrst_out_valid", out_valid, 1);
        chk("postrst_level1", level, 1);
        chk("postrst_data", $signed(out_data), 14);
        step();
        chk("postrst_drained", level, 0);
        step();

        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
